// File: rtl/scaler_output_framer.sv
// Frames the scaler's pixel stream with sof/eol/eof flags and buffers it in a
// first-word-fall-through FIFO. Upstream is throttled through nextDin.
module scaler_output_framer #(
  parameter int DATA_WIDTH         = 8,
  parameter int CHANNELS           = 3,
  parameter int OUTPUT_X_RES_WIDTH = 11,
  parameter int OUTPUT_Y_RES_WIDTH = 11,
  parameter int FIFO_DEPTH_LOG2    = 4,
  parameter int SKID               = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [OUTPUT_X_RES_WIDTH-1:0]    outputXRes,
  input  logic [OUTPUT_Y_RES_WIDTH-1:0]    outputYRes,
  input  logic [DATA_WIDTH*CHANNELS-1:0]   dIn,
  input  logic                             dInValid,
  output logic                             nextDin,
  output logic [DATA_WIDTH*CHANNELS-1:0]   dOut,
  output logic                             dOutValid,
  input  logic                             dOutReady,
  output logic                             sof,
  output logic                             eol,
  output logic                             eof,
  output logic [FIFO_DEPTH_LOG2:0]         fifoLevel,
  output logic                             overflow,
  output logic                             frameDone
);

  localparam int PW    = DATA_WIDTH * CHANNELS;
  localparam int EW    = PW + 3;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] REQ_LIMIT  = (FIFO_DEPTH_LOG2+1)'(DEPTH - SKID);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [OUTPUT_X_RES_WIDTH-1:0] x_cnt, x_res;
  logic [OUTPUT_Y_RES_WIDTH-1:0] y_cnt, y_res;
  logic [FIFO_DEPTH_LOG2-1:0]    rd_ptr, wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]      level;
  logic [EW-1:0]                 mem [DEPTH];
  logic [EW-1:0]                 head;

  logic full, push, drop, pop, in_active, frame_start;
  logic at_first, at_eol, at_eof;

  assign full     = (level == FULL_LEVEL);
  assign pop      = (level != '0) && dOutReady;
  assign at_first = (x_cnt == '0) && (y_cnt == '0);
  assign at_eol   = (x_cnt == x_res);
  assign at_eof   = at_eol && (y_cnt == y_res);

  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start)         state_next = ACTIVE;
      ACTIVE: if (push && at_eof) state_next = IDLE;
    endcase
  end

  // start is only honoured in IDLE; the input side is only open in ACTIVE.
  always_comb begin
    in_active   = 1'b0;
    frame_start = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE:   frame_start = start;
      ACTIVE: begin
        in_active = 1'b1;
        push      = dInValid && !full;
        drop      = dInValid && full;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
      x_res <= '0;
      y_res <= '0;
    end else if (frame_start) begin
      x_res <= outputXRes;
      y_res <= outputYRes;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (push) begin
      if (at_eol) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level
  // alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {at_first, at_eol, at_eof, dIn};
  end

  // Pointers wrap naturally at their FIFO_DEPTH_LOG2-bit width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nextDin   <= 1'b0;
      overflow  <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      nextDin   <= in_active && (level < REQ_LIMIT);
      overflow  <= overflow | drop;
      frameDone <= push && at_eof;
    end
  end

  // Head entry is gated by dOutValid so dOut and flags read 0 when empty.
  assign head      = mem[rd_ptr];
  assign dOutValid = (level != '0);
  assign dOut      = dOutValid ? head[PW-1:0] : '0;
  assign sof       = dOutValid & head[PW+2];
  assign eol       = dOutValid & head[PW+1];
  assign eof       = dOutValid & head[PW];
  assign fifoLevel = level;

endmodule

// File: tb/tb_scaler_output_framer.sv
// Self-checking bench for scaler_output_framer: queue-based reference model
// compared every cycle, plus directed frames with literal expectations.
module tb_scaler_output_framer;

  localparam int DW    = 10;
  localparam int CH    = 4;
  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int DL2   = 3;
  localparam int SKID  = 2;
  localparam int PW    = DW * CH;
  localparam int DEPTH = 1 << DL2;

  logic          clk = 1'b0;
  logic          rst, start, dInValid, dOutReady;
  logic [XW-1:0] outputXRes;
  logic [YW-1:0] outputYRes;
  logic [PW-1:0] dIn, dOut;
  logic          nextDin, dOutValid, sof, eol, eof, overflow, frameDone;
  logic [DL2:0]  fifoLevel;

  scaler_output_framer #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .OUTPUT_X_RES_WIDTH(XW),
    .OUTPUT_Y_RES_WIDTH(YW), .FIFO_DEPTH_LOG2(DL2), .SKID(SKID)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .outputXRes(outputXRes), .outputYRes(outputYRes),
    .dIn(dIn), .dInValid(dInValid), .nextDin(nextDin),
    .dOut(dOut), .dOutValid(dOutValid), .dOutReady(dOutReady),
    .sof(sof), .eol(eol), .eof(eof), .fifoLevel(fifoLevel),
    .overflow(overflow), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] d;
    logic          s;
    logic          l;
    logic          e;
  } ent_t;

  int n_err    = 0;
  int n_checks = 0;
  int done_cnt = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position counters plus a queue standing in for the FIFO.
  ent_t m_q[$];
  ent_t obs[$];
  ent_t m_ent, o_ent;
  bit   m_active = 0, m_ovf = 0, m_next = 0, m_done = 0;
  bit   full_now, push_now, pop_now, next_now;
  int   m_x = 0, m_y = 0, m_xres = 0, m_yres = 0;

  always @(posedge clk) begin
    if (frameDone) done_cnt++;
    if (!rst && dOutValid && dOutReady) begin
      o_ent.d = dOut; o_ent.s = sof; o_ent.l = eol; o_ent.e = eof;
      obs.push_back(o_ent);
    end
    if (rst) begin
      m_q.delete();
      m_active = 0; m_ovf = 0; m_next = 0; m_done = 0;
      m_x = 0; m_y = 0;
    end else begin
      full_now = (m_q.size() == DEPTH);
      pop_now  = (m_q.size() != 0) && dOutReady;
      push_now = m_active && dInValid && !full_now;
      next_now = m_active && (m_q.size() < DEPTH - SKID);
      m_done   = 0;
      if (m_active && dInValid && full_now) m_ovf = 1;
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
        m_ent.d = dIn;
        m_ent.s = (m_x == 0 && m_y == 0);
        m_ent.l = (m_x == m_xres);
        m_ent.e = (m_x == m_xres && m_y == m_yres);
        m_q.push_back(m_ent);
        if (m_ent.e) begin m_active = 0; m_done = 1; end
        if (m_x == m_xres) begin m_x = 0; m_y++; end
        else m_x++;
      end else if (!m_active && start) begin
        m_xres = int'(outputXRes); m_yres = int'(outputYRes);
        m_x = 0; m_y = 0; m_active = 1;
      end
      m_next = next_now;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dOutValid", 64'(dOutValid), 64'(m_q.size() != 0));
      check("fifoLevel", 64'(fifoLevel), 64'(m_q.size()));
      check("nextDin", 64'(nextDin), 64'(m_next));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("frameDone", 64'(frameDone), 64'(m_done));
      if (m_q.size() != 0) begin
        check("dOut", 64'(dOut), 64'(m_q[0].d));
        check("sof", 64'(sof), 64'(m_q[0].s));
        check("eol", 64'(eol), 64'(m_q[0].l));
        check("eof", 64'(eof), 64'(m_q[0].e));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_frame(input int xr, input int yr);
    start = 1; outputXRes = XW'(xr); outputYRes = YW'(yr);
    tick();
    start = 0;
  endtask

  logic [PW-1:0] sent [8];

  initial begin
    rst = 1; start = 0; dInValid = 0; dIn = '0; dOutReady = 0;
    outputXRes = '0; outputYRes = '0;
    repeat (3) tick();
    chk_en = 1;
    check("rst_level", 64'(fifoLevel), 64'd0);
    check("rst_valid", 64'(dOutValid), 64'd0);
    check("rst_nextDin", 64'(nextDin), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_frameDone", 64'(frameDone), 64'd0);
    check("rst_dOut", 64'(dOut), 64'd0);
    rst = 0;
    tick();

    // Frame 4x2, free-running output: literal flag pattern.
    dOutReady = 1;
    start_frame(3, 1);
    obs.delete(); done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      dInValid = 1; dIn = PW'(i);
      tick();
    end
    dInValid = 0;
    repeat (4) tick();
    check("frame_count", 64'(obs.size()), 64'd8);
    for (int k = 0; k < obs.size() && k < 8; k++) begin
      check("frame_data", 64'(obs[k].d), 64'(k + 1));
      check("frame_sof", 64'(obs[k].s), 64'(k == 0));
      check("frame_eol", 64'(obs[k].l), 64'(k == 3 || k == 7));
      check("frame_eof", 64'(obs[k].e), 64'(k == 7));
    end
    check("frame_done_once", 64'(done_cnt), 64'd1);
    check("frame_idle_nextDin", 64'(nextDin), 64'd0);

    // Backpressure then overflow on a 10-pixel line.
    dOutReady = 0;
    start_frame(9, 0);
    obs.delete(); done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      dInValid = 1; dIn = PW'(100 + i);
      tick();
      if (i == 6) begin
        check("bp_level6", 64'(fifoLevel), 64'd6);
        check("bp_nextDin_still_high", 64'(nextDin), 64'd1);
      end
      if (i == 7) check("bp_nextDin_fell", 64'(nextDin), 64'd0);
    end
    check("bp_full", 64'(fifoLevel), 64'd8);
    dInValid = 1; dIn = PW'(40'hDEAD); dOutReady = 1;
    tick();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_level", 64'(fifoLevel), 64'd7);
    dInValid = 0;
    repeat (10) tick();
    for (int i = 9; i <= 10; i++) begin
      dInValid = 1; dIn = PW'(100 + i);
      tick();
    end
    dInValid = 0;
    repeat (4) tick();
    check("ovf_count", 64'(obs.size()), 64'd10);
    for (int k = 0; k < obs.size() && k < 10; k++)
      check("ovf_order", 64'(obs[k].d), 64'(101 + k));
    if (obs.size() >= 10) begin
      check("ovf_x_held_eol9", 64'(obs[8].l), 64'd0);
      check("ovf_x_held_eol10", 64'(obs[9].l), 64'd1);
      check("ovf_eof10", 64'(obs[9].e), 64'd1);
    end
    check("ovf_done_once", 64'(done_cnt), 64'd1);

    // Reset mid-frame with start/valid/ready also asserted.
    dOutReady = 0;
    start_frame(7, 0);
    for (int i = 1; i <= 5; i++) begin
      dInValid = 1; dIn = PW'(200 + i);
      tick();
    end
    rst = 1; start = 1; dInValid = 1; dOutReady = 1;
    tick();
    rst = 0; start = 0; dInValid = 0; dOutReady = 0;
    check("mid_rst_level", 64'(fifoLevel), 64'd0);
    check("mid_rst_valid", 64'(dOutValid), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    tick();
    check("mid_rst_idle", 64'(nextDin), 64'd0);
    start_frame(7, 0);
    obs.delete();
    dOutReady = 1; dInValid = 1; dIn = PW'(300);
    tick();
    dInValid = 0;
    repeat (3) tick();
    check("mid_rst_first_count", 64'(obs.size()), 64'd1);
    if (obs.size() >= 1) begin
      check("mid_rst_first_sof", 64'(obs[0].s), 64'd1);
      check("mid_rst_first_data", 64'(obs[0].d), 64'd300);
    end

    // Full 40-bit data path, start ignored mid-frame.
    rst = 1; tick(); rst = 0; tick();
    start_frame(3, 1);
    obs.delete(); done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      sent[i] = PW'({$urandom, $urandom});
      dInValid = 1; dIn = sent[i];
      dOutReady = $urandom_range(0, 1) == 1;
      if (i == 3) begin start = 1; outputXRes = '0; outputYRes = '0; end
      tick();
      start = 0;
      check("width_frameDone", 64'(frameDone), 64'(i == 7));
    end
    dInValid = 0; dOutReady = 1;
    repeat (10) tick();
    check("width_count", 64'(obs.size()), 64'd8);
    for (int k = 0; k < obs.size() && k < 8; k++) begin
      check("width_data", 64'(obs[k].d), 64'(sent[k]));
      check("width_eol", 64'(obs[k].l), 64'(k == 3 || k == 7));
    end
    check("width_done_once", 64'(done_cnt), 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 39) == 0);
      outputXRes = XW'($urandom_range(0, 5));
      outputYRes = YW'($urandom_range(0, 3));
      dInValid   = ($urandom_range(0, 3) != 0);
      dIn        = PW'({$urandom, $urandom});
      dOutReady  = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; start = 0; dInValid = 0; dOutReady = 1;
    repeat (12) tick();
    check("final_drained", 64'(fifoLevel), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
